// File: rtl/divmod_pkg.sv
// Shared encodings and constants for the signed DIV/MOD execute unit.
package divmod_pkg;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MOD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] QUOT_DIV0 = 32'hFFFF_FFFF;
  localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;
  localparam logic [31:0] ZERO_W    = 32'h0000_0000;

endpackage

// File: rtl/div_nonrestoring32_bk.sv
// Combinational 32-bit signed divider (non-restoring array on magnitudes).
// Quotient truncates toward zero; remainder takes the dividend's sign.
module div_nonrestoring32_bk (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [33:0] part_s;
  logic [31:0] q_s;

  // Unrolled non-restoring iteration followed by a final remainder correction.
  always_comb begin
    neg_a_s = a[31];
    neg_b_s = b[31];
    abs_a_s = neg_a_s ? (32'd0 - a) : a;
    abs_b_s = neg_b_s ? (32'd0 - b) : b;
    part_s  = 34'd0;
    q_s     = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (part_s[33] == 1'b0) begin
        part_s = {part_s[32:0], abs_a_s[i]} - {2'b00, abs_b_s};
      end else begin
        part_s = {part_s[32:0], abs_a_s[i]} + {2'b00, abs_b_s};
      end
      q_s[i] = ~part_s[33];
    end
    if (part_s[33] == 1'b1) begin
      part_s = part_s + {2'b00, abs_b_s};
    end else begin
      part_s = part_s;
    end
    quot = (neg_a_s ^ neg_b_s) ? (32'd0 - q_s) : q_s;
    rem  = neg_a_s ? (32'd0 - part_s[31:0]) : part_s[31:0];
  end

endmodule

// File: rtl/divmod_exec_unit.sv
// Execute-stage issue/retire controller for signed DIV/MOD around div_nonrestoring32_bk.
// Optional DIVMOD_FLUSH_EN adds a flush input that aborts any operation in flight.
module divmod_exec_unit
  import divmod_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int RD_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_div0,
  output logic              busy
`ifdef DIVMOD_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              op_r, op_s;
  logic [DATA_W-1:0] a_r, a_s;
  logic [DATA_W-1:0] b_r, b_s;
  logic [RD_W-1:0]   rd_r, rd_s;
  logic              valid_r, valid_s;
  logic [DATA_W-1:0] result_r, result_s;
  logic [RD_W-1:0]   out_rd_r, out_rd_s;
  logic              div0_r, div0_s;
  logic              in_ready_s;
  logic              flush_s;
  logic [DATA_W-1:0] quot_s;
  logic [DATA_W-1:0] rem_s;

`ifdef DIVMOD_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // The core only ever sees the latched operands, so they stay stable through CALC.
  div_nonrestoring32_bk u_div (
    .a    (a_r),
    .b    (b_r),
    .quot (quot_s),
    .rem  (rem_s)
  );

  assign in_ready_s = (state_r == IDLE) && !flush_s;
  assign in_ready   = in_ready_s;
  assign busy       = (state_r != IDLE);
  assign out_valid  = valid_r;
  assign out_result = result_r;
  assign out_rd     = out_rd_r;
  assign out_div0   = div0_r;

  // Next-state and next-register values; special cases bypass CALC entirely.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    a_s      = a_r;
    b_s      = b_r;
    rd_s     = rd_r;
    valid_s  = valid_r;
    result_s = result_r;
    out_rd_s = out_rd_r;
    div0_s   = div0_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_s) begin
          op_s = in_op;
          a_s  = in_a;
          b_s  = in_b;
          rd_s = in_rd;
          if (in_b == ZERO_W) begin
            state_s  = DONE;
            valid_s  = 1'b1;
            result_s = (in_op == OP_MOD) ? in_a : QUOT_DIV0;
            out_rd_s = in_rd;
            div0_s   = 1'b1;
          end else if ((in_a == INT_MIN) && (in_b == NEG_ONE)) begin
            state_s  = DONE;
            valid_s  = 1'b1;
            result_s = (in_op == OP_MOD) ? ZERO_W : INT_MIN;
            out_rd_s = in_rd;
            div0_s   = 1'b0;
          end else begin
            state_s = CALC;
            cnt_s   = CNT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 4'd0) begin
          state_s  = DONE;
          valid_s  = 1'b1;
          result_s = (op_r == OP_MOD) ? rem_s : quot_s;
          out_rd_s = rd_r;
          div0_s   = 1'b0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
    // Flush wins over acceptance, handshake and CALC completion alike.
    if (flush_s) begin
      state_s = IDLE;
      valid_s = 1'b0;
      div0_s  = 1'b0;
      cnt_s   = 4'd0;
    end else begin
      state_s = state_s;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      op_r     <= OP_DIV;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      rd_r     <= {RD_W{1'b0}};
      valid_r  <= 1'b0;
      result_r <= ZERO_W;
      out_rd_r <= {RD_W{1'b0}};
      div0_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      a_r      <= a_s;
      b_r      <= b_s;
      rd_r     <= rd_s;
      valid_r  <= valid_s;
      result_r <= result_s;
      out_rd_r <= out_rd_s;
      div0_r   <= div0_s;
    end
  end

endmodule
